// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the register file, its write arbiter and the hazard logic.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Width of an index over n requesters; at least one bit so n=1 still builds.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant over a request vector, starting the search at ptr_i.
// Latency: purely combinational.
// Backpressure: en_i low forces an all-zero grant.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  // Walk the requesters starting at ptr_i, wrapping at NUM_REQ; the first one valid wins.
  always_comb begin
    int cand;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en_i && !vld_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
        vld_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback requesters, round-robin.
// Latency: one cycle from accept to rf_write_enable; one write per cycle sustained.
// Backpressure: req_ready is combinational and is all-zero while hold or reset is high.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter bit DROP_R0 = 1'b1,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      pend_valid,
  output logic [ADDR_W-1:0]         pend_addr,
  output logic [DATA_W-1:0]         pend_data
);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_drop;

  logic              we_q, we_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  gid_q, gid_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (!hold && !reset),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (xfer)
  );

  assign req_ready = gnt;

  // Pick the winner's address/data and decide whether it is a write to the hardwired zero register.
  always_comb begin
    sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    sel_drop = DROP_R0 && (sel_addr == ADDR_W'(ZERO_REG));
  end

  // Next-state: pointer moves just past the winner; the stage captures a transfer, else holds addr/data.
  always_comb begin
    ptr_d      = ptr_q;
    pend_vld_d = xfer;
    we_d       = xfer && !sel_drop;
    addr_d     = addr_q;
    data_d     = data_q;
    gid_d      = gid_q;
    if (xfer) begin
      ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      addr_d = sel_addr;
      data_d = sel_data;
      gid_d  = gnt_idx;
    end
  end

  // Pointer and output stage registers; the enable is a flop so the register file sees a clean pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      we_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      gid_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      pend_vld_q <= pend_vld_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      gid_q      <= gid_d;
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = addr_q;
  assign rf_write_data   = data_q;
  assign grant_id        = gid_q;
  assign pend_valid      = pend_vld_q;
  assign pend_addr       = addr_q;
  assign pend_data       = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a scoreboard of expected write-stage contents.
// Two instances share stimulus: one dropping R0 writes, one not.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset, hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;

  logic [N-1:0]  rdy, rdy_nd;
  logic          we, we_nd, pv, pv_nd;
  logic [AW-1:0] wa, wa_nd, pa, pa_nd;
  logic [DW-1:0] wd, wd_nd, pd, pd_nd;
  logic [IW-1:0] gid, gid_nd;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DROP_R0(1'b1)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(rdy), .req_addr(req_addr), .req_data(req_data),
    .rf_write_enable(we), .rf_write_addr(wa), .rf_write_data(wd), .grant_id(gid),
    .pend_valid(pv), .pend_addr(pa), .pend_data(pd)
  );

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DROP_R0(1'b0)) dut_nd (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(rdy_nd), .req_addr(req_addr), .req_data(req_data),
    .rf_write_enable(we_nd), .rf_write_addr(wa_nd), .rf_write_data(wd_nd), .grant_id(gid_nd),
    .pend_valid(pv_nd), .pend_addr(pa_nd), .pend_data(pd_nd)
  );

  typedef struct packed {
    logic          we;
    logic          we_nd;
    logic          pv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] gid;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] a_t[N];
  logic [DW-1:0] d_t[N];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic [IW-1:0] last_gid;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_we"},      64'(we),     64'(e.we));
    chk({tag, "_pv"},      64'(pv),     64'(e.pv));
    chk({tag, "_addr"},    64'(wa),     64'(e.addr));
    chk({tag, "_data"},    64'(wd),     64'(e.data));
    chk({tag, "_gid"},     64'(gid),    64'(e.gid));
    chk({tag, "_paddr"},   64'(pa),     64'(e.addr));
    chk({tag, "_pdata"},   64'(pd),     64'(e.data));
    chk({tag, "_we_nd"},   64'(we_nd),  64'(e.we_nd));
    chk({tag, "_pv_nd"},   64'(pv_nd),  64'(e.pv));
    chk({tag, "_addr_nd"}, 64'(wa_nd),  64'(e.addr));
    chk({tag, "_gid_nd"},  64'(gid_nd), 64'(e.gid));
  endtask

  // One clock cycle: drive inputs, check the stage against the scoreboard, check ready against the
  // directed expectation, then push what the stage must show next cycle.
  task automatic cycle(input string tag, input logic [N-1:0] v, input logic h, input logic r,
                       input logic [N-1:0] exp_rdy);
    exp_t e;
    req_valid = v;
    hold      = h;
    reset     = r;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a_t[i];
      req_data[i*DW +: DW] = d_t[i];
    end
    @(negedge clk);
    pop_check(tag);
    chk({tag, "_ready"},    64'(rdy),    64'(exp_rdy));
    chk({tag, "_ready_nd"}, 64'(rdy_nd), 64'(exp_rdy));
    if (r) begin
      last_addr = '0;
      last_data = '0;
      last_gid  = '0;
      e = '0;
    end else if (exp_rdy != '0) begin
      for (int i = 0; i < N; i++) begin
        if (exp_rdy[i]) begin
          last_addr = a_t[i];
          last_data = d_t[i];
          last_gid  = IW'(i);
        end
      end
      e.we    = (last_addr != '0);
      e.we_nd = 1'b1;
      e.pv    = 1'b1;
      e.addr  = last_addr;
      e.data  = last_data;
      e.gid   = last_gid;
    end else begin
      e.we    = 1'b0;
      e.we_nd = 1'b0;
      e.pv    = 1'b0;
      e.addr  = last_addr;
      e.data  = last_data;
      e.gid   = last_gid;
    end
    sb.push_back(e);
    // An accepted requester presents fresh data on its next request.
    for (int i = 0; i < N; i++)
      if (exp_rdy[i] && !r) d_t[i] = d_t[i] + 32'h0000_0100;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e0;
    reset = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      a_t[i] = AW'(i + 1);
      d_t[i] = 32'hA000_0000 + 32'(i);
    end
    last_addr = '0;
    last_data = '0;
    last_gid  = '0;
    repeat (2) @(posedge clk);
    #1;
    e0 = '0;
    sb.push_back(e0);

    // Single request from requester 0; reset values checked by the first pop.
    a_t[0] = 5'd5;
    d_t[0] = 32'hDEAD_BEEF;
    cycle("single",    3'b001, 1'b0, 1'b1, 3'b000);
    cycle("single",    3'b001, 1'b0, 1'b0, 3'b001);
    cycle("single_wr", 3'b000, 1'b0, 1'b0, 3'b000);
    cycle("single_lo", 3'b000, 1'b0, 1'b0, 3'b000);

    // Pointer wrap: pointer is 1; grant 1 moves it to 2, then 011 must go to 0, then to 1.
    a_t[0] = 5'd1;
    cycle("wrap_g1", 3'b010, 1'b0, 1'b0, 3'b010);
    cycle("wrap_g0", 3'b011, 1'b0, 1'b0, 3'b001);
    cycle("wrap_g1b", 3'b011, 1'b0, 1'b0, 3'b010);
    cycle("wrap_g2", 3'b100, 1'b0, 1'b0, 3'b100);

    // Fairness: everyone valid, pointer at 0, grants 0,1,2,0,1,2 with continuous enable.
    cycle("rr0", 3'b111, 1'b0, 1'b0, 3'b001);
    cycle("rr1", 3'b111, 1'b0, 1'b0, 3'b010);
    cycle("rr2", 3'b111, 1'b0, 1'b0, 3'b100);
    cycle("rr3", 3'b111, 1'b0, 1'b0, 3'b001);
    cycle("rr4", 3'b111, 1'b0, 1'b0, 3'b010);
    cycle("rr5", 3'b111, 1'b0, 1'b0, 3'b100);

    // Hold: write accepted just before hold still lands; grants resume at the pointer (1).
    cycle("pre_hold", 3'b111, 1'b0, 1'b0, 3'b001);
    cycle("hold0",    3'b111, 1'b1, 1'b0, 3'b000);
    cycle("hold1",    3'b111, 1'b1, 1'b0, 3'b000);
    cycle("hold2",    3'b111, 1'b1, 1'b0, 3'b000);
    cycle("resume",   3'b111, 1'b0, 1'b0, 3'b010);
    cycle("drain",    3'b000, 1'b0, 1'b0, 3'b000);

    // R0: staged as pending but only the non-dropping instance enables the write.
    a_t[0] = 5'd0;
    d_t[0] = 32'h0000_1234;
    cycle("r0",      3'b001, 1'b0, 1'b0, 3'b001);
    cycle("r0_wr",   3'b000, 1'b0, 1'b0, 3'b000);
    cycle("r0_idle", 3'b000, 1'b0, 1'b0, 3'b000);

    // Reset mid-operation: write to r7 accepted, then reset; afterwards all zero, grant restarts at 0.
    a_t[0] = 5'd1;
    a_t[1] = 5'd7;
    cycle("rst_acc",  3'b010, 1'b0, 1'b0, 3'b010);
    cycle("rst_in",   3'b111, 1'b0, 1'b1, 3'b000);
    cycle("rst_post", 3'b111, 1'b0, 1'b0, 3'b001);
    cycle("rst_tail", 3'b000, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    pop_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
